// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory arbiter.
//   DATA_W      : data/address width of the memory path
//   DMEM_DEPTH  : default number of 32-bit words in the data memory
//   port_e      : requester index (CPU load/store port, loader/debug port)
//   rr_pick     : round-robin pick, returns a one-hot grant vector
package dmem_pkg;

    localparam int DATA_W     = 32;
    localparam int DMEM_DEPTH = 1024;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    // On contention the port that did not win last time gets the grant;
    // a lone request is passed straight through.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input port_e last);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == PORT_CPU) ? 2'b10 : 2'b01;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with
// combinational read.
//   clk, rst                 : clock, synchronous active-high reset
//   pN_req/we/addr/wdata     : requester N access (p0 = CPU, p1 = loader/debug)
//   pN_gnt                   : combinational grant, same cycle as the request
//   pN_rvalid/rdata/err      : response one cycle after a read or an
//                              out-of-range access; err flags addr >= DEPTH
//   mem_we/mem_a/mem_wd/mem_rd : data memory port
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    port_e                        last_gnt_q, last_gnt_d;
    logic  [1:0]                  rvalid_q, rvalid_d;
    logic  [1:0]                  err_q, err_d;
    logic  [1:0][DATA_W-1:0]      rdata_q, rdata_d;

    logic  [1:0]                  gnt;
    logic                         any_gnt;
    logic                         sel;
    logic                         sel_we;
    logic                         sel_inr;
    logic  [DATA_W-1:0]           sel_addr;
    logic  [DATA_W-1:0]           sel_wd;

    always_comb begin
        // Reset blocks every grant so nothing reaches memory or the response path.
        gnt      = rst ? 2'b00 : rr_pick({p1_req, p0_req}, last_gnt_q);
        any_gnt  = |gnt;
        sel      = gnt[1];
        sel_we   = sel ? p1_we    : p0_we;
        sel_addr = sel ? p1_addr  : p0_addr;
        sel_wd   = sel ? p1_wdata : p0_wdata;
        sel_inr  = (sel_addr < DEPTH_W);

        mem_we   = any_gnt & sel_we & sel_inr;
        mem_a    = any_gnt ? sel_addr : '0;
        mem_wd   = any_gnt ? sel_wd   : '0;

        last_gnt_d = last_gnt_q;
        rvalid_d   = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;

        if (any_gnt) begin
            last_gnt_d = port_e'(sel);
            if (!sel_inr) begin
                // Out-of-range: error response; a write is dropped and keeps rdata.
                rvalid_d[sel] = 1'b1;
                err_d[sel]    = 1'b1;
                if (!sel_we) begin
                    rdata_d[sel] = '0;
                end
            end else if (!sel_we) begin
                rvalid_d[sel] = 1'b1;
                rdata_d[sel]  = mem_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= PORT_LDR;
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Responses are masked during reset so a response pending when reset
    // arrives is never seen.
    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid_q[0] & ~rst;
    assign p1_rvalid = rvalid_q[1] & ~rst;
    assign p0_err    = err_q[0] & ~rst;
    assign p1_err    = err_q[1] & ~rst;
    assign p0_rdata  = rst ? '0 : rdata_q[0];
    assign p1_rdata  = rst ? '0 : rdata_q[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized + directed bench for data_mem_arbiter, checked against a
// transaction-level model (winner choice, reference memory, pending responses).
module tb_data_mem_arbiter;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i, we_i;
    logic [31:0] addr_i [2];
    logic [31:0] wd_i [2];
    logic [1:0]  gnt_o, rv_o, err_o;
    logic [31:0] rd_o [2];
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int          last;
    logic [1:0]  m_rv, m_err;
    logic [31:0] m_rd [2];
    int          wait_cnt [2];

    // last sampled DUT values, for directed checks
    logic [1:0]  s_gnt, s_rv, s_err;
    logic        s_we;
    logic [31:0] s_a, s_wd, s_rd0, s_rd1;

    always #5 clk = ~clk;

    assign mem_rd = (mem_a < DEPTH) ? env_mem[mem_a[9:0]] : 32'hBAD0_BAD0;

    data_mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req_i[0]), .p0_we(we_i[0]), .p0_addr(addr_i[0]), .p0_wdata(wd_i[0]),
        .p0_gnt(gnt_o[0]), .p0_rvalid(rv_o[0]), .p0_rdata(rd_o[0]), .p0_err(err_o[0]),
        .p1_req(req_i[1]), .p1_we(we_i[1]), .p1_addr(addr_i[1]), .p1_wdata(wd_i[1]),
        .p1_gnt(gnt_o[1]), .p1_rvalid(rv_o[1]), .p1_rdata(rd_o[1]), .p1_err(err_o[1]),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        req_i = 2'b00;
        we_i  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr_i[p] = '0;
            wd_i[p]   = '0;
        end
    endtask

    task automatic acc(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_i[p]  = 1'b1;
        we_i[p]   = w;
        addr_i[p] = a;
        wd_i[p]   = d;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the
    // model and the environment memory past the rising edge.
    task automatic cycle();
        int          win;
        logic [1:0]  eg;
        logic [31:0] a;
        @(negedge clk);
        win = -1;
        if (!rst) begin
            if (req_i == 2'b11)  win = 1 - last;
            else if (req_i[0])   win = 0;
            else if (req_i[1])   win = 1;
        end
        eg = 2'b00;
        if (win == 0) eg = 2'b01;
        if (win == 1) eg = 2'b10;

        s_gnt = gnt_o; s_we = mem_we; s_a = mem_a; s_wd = mem_wd;
        s_rv = rv_o; s_err = err_o; s_rd0 = rd_o[0]; s_rd1 = rd_o[1];

        chk("gnt", {30'd0, gnt_o}, {30'd0, eg});
        chk("mem_a", mem_a, (win >= 0) ? addr_i[win] : 32'd0);
        chk("mem_wd", mem_wd, (win >= 0) ? wd_i[win] : 32'd0);
        chk("mem_we", {31'd0, mem_we},
            {31'd0, (win >= 0) && we_i[win] && (addr_i[win] < DEPTH)});
        chk("rvalid", {30'd0, rv_o}, rst ? 32'd0 : {30'd0, m_rv});
        chk("err", {30'd0, err_o}, rst ? 32'd0 : {30'd0, m_err});
        chk("rdata0", rd_o[0], rst ? 32'd0 : m_rd[0]);
        chk("rdata1", rd_o[1], rst ? 32'd0 : m_rd[1]);

        for (int p = 0; p < 2; p++) begin
            if (rst || !req_i[p]) wait_cnt[p] = 0;
            else if (win == p) begin
                chk("no_starve", 32'(wait_cnt[p] <= 1), 32'd1);
                wait_cnt[p] = 0;
            end else wait_cnt[p]++;
        end

        @(posedge clk);
        #1;
        if (s_we && s_a < DEPTH) env_mem[s_a[9:0]] = s_wd;

        if (rst) begin
            m_rv = 2'b00; m_err = 2'b00; m_rd[0] = '0; m_rd[1] = '0; last = 1;
        end else begin
            m_rv = 2'b00; m_err = 2'b00;
            if (win >= 0) begin
                a = addr_i[win];
                last = win;
                if (a >= DEPTH) begin
                    m_rv[win] = 1'b1; m_err[win] = 1'b1;
                    if (!we_i[win]) m_rd[win] = '0;
                end else if (we_i[win]) begin
                    ref_mem[a[9:0]] = wd_i[win];
                end else begin
                    m_rv[win] = 1'b1; m_rd[win] = ref_mem[a[9:0]];
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 32'(i + 2);
            ref_mem[i] = 32'(i + 2);
        end
        last = 1; m_rv = 2'b00; m_err = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;

        // reset, with requests held high in the second cycle
        rst = 1'b1; idle();
        cycle();
        acc(0, 1'b1, 32'd3, 32'h1111_1111); acc(1, 1'b1, 32'd4, 32'h2222_2222);
        cycle();
        chk("rst_gnt", {30'd0, s_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, s_we}, 32'd0);
        chk("rst_rdata0", s_rd0, 32'd0);
        rst = 1'b0;

        // both ports contend for 4 cycles: p0, p1, p0, p1
        idle(); acc(0, 1'b0, 32'd100, 32'd0); acc(1, 1'b0, 32'd200, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_gnt", {30'd0, s_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_mem_a", s_a, (i % 2 == 0) ? 32'd100 : 32'd200);
        end
        idle(); cycle();

        // p0 read of addr 30 (holds 0x20)
        acc(0, 1'b0, 32'd30, 32'd0); cycle();
        chk("rd30_gnt", {30'd0, s_gnt}, 32'd1);
        idle(); cycle();
        chk("rd30_rvalid", {30'd0, s_rv}, 32'd1);
        chk("rd30_rdata", s_rd0, 32'h20);

        // p1 writes 0xDEADBEEF to addr 5, then p0 reads it back
        acc(1, 1'b1, 32'd5, 32'hDEAD_BEEF); cycle();
        chk("wr5_we", {31'd0, s_we}, 32'd1);
        idle(); acc(0, 1'b0, 32'd5, 32'd0); cycle();
        chk("rd5_we", {31'd0, s_we}, 32'd0);
        chk("wr5_no_rvalid", {30'd0, s_rv}, 32'd0);
        idle(); cycle();
        chk("rd5_rdata", s_rd0, 32'hDEAD_BEEF);

        // p0 out-of-range write to 1024
        acc(0, 1'b1, 32'd1024, 32'h1234_5678); cycle();
        chk("oor_we", {31'd0, s_we}, 32'd0);
        idle(); cycle();
        chk("oor_rvalid", {30'd0, s_rv}, 32'd1);
        chk("oor_err", {30'd0, s_err}, 32'd1);
        chk("oor_rdata_kept", s_rd0, 32'hDEAD_BEEF);
        chk("oor_mem0", env_mem[0], 32'd2);

        // p1 read granted, reset the next cycle: response discarded
        acc(1, 1'b0, 32'd7, 32'd0); cycle();
        rst = 1'b1; idle(); cycle();
        chk("rst_drop_rvalid", {30'd0, s_rv}, 32'd0);
        chk("rst_drop_rdata1", s_rd1, 32'd0);
        rst = 1'b0;
        acc(0, 1'b0, 32'd8, 32'd0); acc(1, 1'b0, 32'd9, 32'd0); cycle();
        chk("post_rst_gnt", {30'd0, s_gnt}, 32'd1);
        idle(); cycle();
        chk("post_rst_no_p1_rvalid", {31'd0, s_rv[1]}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int p = 0; p < 2; p++) begin
                req_i[p]  = $urandom_range(0, 2) != 0;
                we_i[p]   = $urandom_range(0, 1) != 0;
                addr_i[p] = ($urandom_range(0, 7) == 0) ? 32'(1020 + $urandom_range(0, 10))
                                                        : 32'($urandom_range(0, 31));
                wd_i[p]   = $urandom;
            end
            cycle();
        end
        rst = 1'b0; idle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
